weight_bias_read_responder: RTL
===============================

Name: weight_bias_read_responder

Overview:
- Memory-side responder for the layer weight/bias read channels.
- Accepts the already-arbitrated read request (signal + 16-bit address + layer select) on independent weight and bias channels.
- Drives the weight/bias SRAM macros, which have 1-cycle read latency, and returns data with a one-cycle valid pulse to the layer that issued the request.
- Fully pipelined: one new request per channel per cycle.

Parameters:
- ADDR_W, 16, request address width.
- DATA_W, 16, weight/bias word width.
- WEIGHT_DEPTH, 4096, valid weight words; address >= WEIGHT_DEPTH is out of range.
- BIAS_DEPTH, 64, valid bias words; address >= BIAS_DEPTH is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- weight_sel  in  5  requesting layer for the weight channel (1 = layer1, 2 = layer2).
- bias_sel  in  5  requesting layer for the bias channel.
- read_weight_signal_data  in  1  weight read request.
- read_weight_addr_data  in  ADDR_W  weight word address.
- read_bias_signal_data  in  1  bias read request.
- read_bias_addr_data  in  ADDR_W  bias word address.
- weight_sram_cs  out  1  weight SRAM chip select (read).
- weight_sram_addr  out  ADDR_W  weight SRAM address.
- weight_sram_dout  in  DATA_W  weight SRAM read data, valid 1 cycle after cs.
- bias_sram_cs  out  1  bias SRAM chip select.
- bias_sram_addr  out  ADDR_W  bias SRAM address.
- bias_sram_dout  in  DATA_W  bias SRAM read data.
- weight_data  out  DATA_W  returned weight word.
- layer1_weight_valid  out  1  weight_data is for layer1.
- layer2_weight_valid  out  1  weight_data is for layer2.
- bias_data  out  DATA_W  returned bias word.
- layer1_bias_valid  out  1  bias_data is for layer1.
- layer2_bias_valid  out  1  bias_data is for layer2.
- addr_err  out  1  sticky flag: any out-of-range request since reset.
- weight_req_count  out  16  accepted weight requests, saturating at 16'hFFFF.
- bias_req_count  out  16  accepted bias requests, saturating at 16'hFFFF.

Behaviour:
- Reset (rst = 0, asynchronous) clears every output and all internal pipeline state to 0: sram cs/addr, data, valids, addr_err, counters.
- A request is accepted at edge N when signal = 1 and sel is 1 or 2.
- signal = 1 with any other sel is ignored: no SRAM access, no count, no response.
- Stage 0, edge N: register sram_cs = 1 and sram_addr = address. Capture dest (sel) and an in-range bit alongside. sram_cs returns to 0 at the next edge if there is no new request.
- Stage 1, edge N+1: SRAM dout is valid. At edge N+2, register data into weight_data/bias_data and raise exactly one layerX valid according to the captured dest.
- Latency is 2 edges from request to valid. Valid is a 1-cycle pulse per request.
- Back-to-back requests give back-to-back valid pulses in request order.
- Data outputs hold their last value when valid is low.
- Out-of-range address:
  - sram_cs stays 0.
  - The response still returns on schedule with data = 0 and the correct layer valid.
  - addr_err sets to 1 and holds until reset.
  - The request is still counted.
- sel changes while requests are in flight: each response follows its own captured sel, never the current input.
- The weight and bias channels are fully independent. Simultaneous requests on both channels each respond at N+2.
- The counters increment by 1 per accepted request and saturate at 0xFFFF (no wrap).
- Reset mid-flight: pending responses are discarded and no valid is emitted after rst deasserts.
- Never drive two valids of the same channel high in one cycle.

Test Plan:
- Reset, then weight req sel=1 addr=0x0010 at edge N with SRAM model returning 0xA5A5 -> weight_sram_cs=1/addr=0x0010 after N; layer1_weight_valid=1, weight_data=0xA5A5 after N+2 only; count=1.
- Weight reqs on 3 consecutive edges: sel 1,2,1 at addrs 1,2,3, sel toggled to 2 after the last one -> valids layer1,layer2,layer1 on 3 consecutive cycles with data mem[1],mem[2],mem[3].
- Bias req sel=2 addr=BIAS_DEPTH (64) -> bias_sram_cs stays 0; layer2_bias_valid pulses at N+2 with bias_data=0; addr_err=1 and stays 1.
- signal=1 with sel=0 and with sel=3 -> no cs, no valid, counters unchanged.
- Simultaneous weight (sel=1) and bias (sel=2) reqs, then rst pulsed low one cycle later -> all outputs 0 immediately; no valid after release; counters 0.
- Force weight_req_count to 0xFFFE via 0xFFFE requests (or a fast sim), then 3 more -> count reads 0xFFFF and holds.

Source files
------------

// File: rtl/weight_bias_read_responder.sv
// weight_bias_read_responder: memory-side responder for the weight and bias read channels.
// Ports: clk/rst (async, active-low); weight_sel/bias_sel plus read_*_signal_data and
// read_*_addr_data carry the arbitrated requests; *_sram_cs/*_sram_addr/*_sram_dout talk to
// the 1-cycle-latency SRAMs; weight_data/bias_data with layer1/layer2 valid pulses return
// responses two edges after the request; addr_err is sticky; *_req_count saturate at 16'hFFFF.

module wbrr_channel #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        sel,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              sram_cs,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic [DATA_W-1:0] data,
    output logic              l1_valid,
    output logic              l2_valid,
    output logic              oor,
    output logic [15:0]       req_count
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    logic acc, in_range;
    logic v0, l2_0, inr0, v1, l2_1, inr1;
    assign acc      = req && (sel == 5'd1 || sel == 5'd2);
    assign in_range = {1'b0, addr} < LIMIT;
    assign oor      = acc && !in_range;
    // Out-of-range requests still travel down the pipeline so they answer on schedule with zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_cs   <= 1'b0;
            sram_addr <= '0;
            v0        <= 1'b0;
            l2_0      <= 1'b0;
            inr0      <= 1'b0;
            v1        <= 1'b0;
            l2_1      <= 1'b0;
            inr1      <= 1'b0;
            data      <= '0;
            l1_valid  <= 1'b0;
            l2_valid  <= 1'b0;
            req_count <= '0;
        end else begin
            sram_cs <= acc && in_range;
            if (acc) sram_addr <= addr;
            v0   <= acc;
            l2_0 <= sel == 5'd2;
            inr0 <= in_range;
            v1   <= v0;
            l2_1 <= l2_0;
            inr1 <= inr0;
            l1_valid <= v1 && !l2_1;
            l2_valid <= v1 && l2_1;
            if (v1) data <= inr1 ? sram_dout : '0;
            if (acc && req_count != 16'hFFFF) req_count <= req_count + 16'd1;
        end
    end
endmodule

module weight_bias_read_responder #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WEIGHT_DEPTH = 4096,
    parameter int BIAS_DEPTH   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        weight_sel,
    input  logic [4:0]        bias_sel,
    input  logic              read_weight_signal_data,
    input  logic [ADDR_W-1:0] read_weight_addr_data,
    input  logic              read_bias_signal_data,
    input  logic [ADDR_W-1:0] read_bias_addr_data,
    output logic              weight_sram_cs,
    output logic [ADDR_W-1:0] weight_sram_addr,
    input  logic [DATA_W-1:0] weight_sram_dout,
    output logic              bias_sram_cs,
    output logic [ADDR_W-1:0] bias_sram_addr,
    input  logic [DATA_W-1:0] bias_sram_dout,
    output logic [DATA_W-1:0] weight_data,
    output logic              layer1_weight_valid,
    output logic              layer2_weight_valid,
    output logic [DATA_W-1:0] bias_data,
    output logic              layer1_bias_valid,
    output logic              layer2_bias_valid,
    output logic              addr_err,
    output logic [15:0]       weight_req_count,
    output logic [15:0]       bias_req_count
);
    logic w_oor, b_oor;
    wbrr_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(WEIGHT_DEPTH)) u_weight (
        .clk(clk), .rst(rst), .sel(weight_sel), .req(read_weight_signal_data),
        .addr(read_weight_addr_data), .sram_cs(weight_sram_cs), .sram_addr(weight_sram_addr),
        .sram_dout(weight_sram_dout), .data(weight_data), .l1_valid(layer1_weight_valid),
        .l2_valid(layer2_weight_valid), .oor(w_oor), .req_count(weight_req_count)
    );
    wbrr_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(BIAS_DEPTH)) u_bias (
        .clk(clk), .rst(rst), .sel(bias_sel), .req(read_bias_signal_data),
        .addr(read_bias_addr_data), .sram_cs(bias_sram_cs), .sram_addr(bias_sram_addr),
        .sram_dout(bias_sram_dout), .data(bias_data), .l1_valid(layer1_bias_valid),
        .l2_valid(layer2_bias_valid), .oor(b_oor), .req_count(bias_req_count)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) addr_err <= 1'b0;
        else if (w_oor || b_oor) addr_err <= 1'b1;
    end
endmodule
